// File: rtl/down_counter_timer.sv
//------------------------------------------------------------------------------
// Module   : down_counter_timer
// Brief    : Loadable down-counter / countdown timer, one-shot or periodic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_enable,
  input  logic             i_periodic,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_tc,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] w_next_val;

  // Same-cycle load bypasses the reload register for both start and reload.
  assign w_next_val = i_load ? i_load_value : reload_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else if (i_start && (state_q != ST_RUN)) begin
      if (i_load) reload_d = i_load_value;
      if (w_next_val == C_ZERO) begin
        tc_d    = 1'b1;
        count_d = C_ZERO;
        state_d = i_periodic ? ST_IDLE : ST_DONE;
      end else begin
        count_d = w_next_val;
        state_d = ST_RUN;
      end
    end else begin
      if (i_load) begin
        reload_d = i_load_value;
        if (state_q != ST_RUN) begin
          count_d = i_load_value;
          state_d = ST_IDLE;
        end
      end
      if ((state_q == ST_RUN) && i_enable) begin
        if (count_q > C_ONE) begin
          count_d = count_q - C_ONE;
        end else begin
          // Terminal (count of 0 in RUN is unreachable but also treated as terminal, so no wrap).
          tc_d = 1'b1;
          if (i_periodic && (w_next_val != C_ZERO)) begin
            count_d = w_next_val;
          end else begin
            count_d = C_ZERO;
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= C_ZERO;
      reload_q <= C_ZERO;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign o_count = count_q;
  assign o_busy  = busy_q;
  assign o_tc    = tc_q;
  assign o_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_down_counter_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_down_counter_timer
// Brief    : Directed and randomized bench for down_counter_timer with a model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_down_counter_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             resetn, i_load, i_start, i_enable, i_periodic, i_abort;
  logic [WIDTH-1:0] i_load_value;
  logic [WIDTH-1:0] o_count;
  logic             o_busy, o_tc, o_done;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = waiting, 1 = counting, 2 = expired.
  int m_mode, m_count, m_reload, m_tc;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_load      (i_load),
    .i_load_value(i_load_value),
    .i_start     (i_start),
    .i_enable    (i_enable),
    .i_periodic  (i_periodic),
    .i_abort     (i_abort),
    .o_count     (o_count),
    .o_busy      (o_busy),
    .o_tc        (o_tc),
    .o_done      (o_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    int s;
    s = i_load ? int'(i_load_value) : m_reload;
    m_tc = 0;
    if (!resetn) begin
      m_mode = 0; m_count = 0; m_reload = 0;
      return;
    end
    if (i_abort) begin
      m_mode = 0;
      return;
    end
    if (i_load) m_reload = i_load_value;
    case (m_mode)
      0, 2: begin
        if (i_start) begin
          if (s == 0) begin
            m_tc = 1; m_count = 0; m_mode = i_periodic ? 0 : 2;
          end else begin
            m_count = s; m_mode = 1;
          end
        end else if (i_load) begin
          m_count = i_load_value; m_mode = 0;
        end
      end
      default: begin
        if (i_enable) begin
          m_count = m_count - 1;
          if (m_count <= 0) begin
            m_tc = 1;
            if (i_periodic && s != 0) m_count = s;
            else begin m_count = 0; m_mode = 2; end
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check("count", o_count, m_count);
    check("busy",  o_busy,  m_mode == 1);
    check("tc",    o_tc,    m_tc);
    check("done",  o_done,  m_mode == 2);
  endtask

  task automatic drive(input logic rn, input logic ld, input int val, input logic st,
                       input logic en, input logic per, input logic ab);
    resetn = rn; i_load = ld; i_load_value = val[WIDTH-1:0]; i_start = st;
    i_enable = en; i_periodic = per; i_abort = ab;
    tick();
  endtask

  initial begin
    m_mode = 0; m_count = 0; m_reload = 0; m_tc = 0;
    // Reset
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_count", o_count, 0);
    check("rst_busy", o_busy, 0);

    // One-shot from 3
    drive(1, 1, 3, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    check("os_start", o_count, 3);
    drive(1, 0, 0, 0, 1, 0, 0);
    check("os_2", o_count, 2);
    drive(1, 0, 0, 0, 1, 0, 0);
    check("os_1", o_count, 1);
    drive(1, 0, 0, 0, 1, 0, 0);
    check("os_tc", {o_count, o_tc, o_done, o_busy}, {8'd0, 3'b110});
    drive(1, 0, 0, 0, 1, 0, 0);
    check("os_hold_done", {o_tc, o_done}, 2'b01);

    // Periodic with gaps from 4
    drive(1, 1, 4, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    check("per_gap", o_count, 3);
    drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    check("per_reload", {o_count, o_tc, o_busy}, {8'd4, 2'b11});

    // Load during RUN, then same-cycle load at terminal
    drive(1, 0, 0, 0, 0, 1, 1);
    drive(1, 1, 5, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 1, 'h10, 0, 1, 1, 0);
    check("ldrun_cont", o_count, 1);
    drive(1, 0, 0, 0, 1, 1, 0);
    check("ldrun_reload", o_count, 'h10);
    for (int k = 0; k < 15; k++) drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 1, 'h20, 0, 1, 1, 0);
    check("ld_at_tc", {o_count, o_tc}, {8'h20, 1'b1});

    // Abort at 7
    for (int k = 0; k < 25; k++) drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 1, 1);
    check("abort_hold", {o_count, o_busy, o_tc}, {8'h07, 2'b00});

    // Zero start, then abort+start in DONE
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    check("zero_start", {o_tc, o_done, o_busy}, 3'b110);
    drive(1, 0, 0, 1, 0, 0, 1);
    check("abort_start", {o_count, o_done}, {8'd0, 1'b0});

    // Start during RUN ignored; reset mid-run at 5
    drive(1, 1, 9, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    check("start_in_run", o_count, 8);
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    check("pre_rst", o_count, 5);
    #2 resetn = 0; #2 resetn = 1;
    tick();
    check("glitch", o_count, 4);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    check("rst_mid", {o_count, o_busy, o_tc, o_done}, {8'd0, 3'b000});

    // 0xFF one-shot, no wrap
    drive(1, 1, 'hFF, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 255; k++) drive(1, 0, 0, 0, 1, 0, 0);
    check("ff_end", {o_count, o_done}, {8'd0, 1'b1});
    drive(1, 0, 0, 0, 1, 0, 0);
    check("ff_nowrap", o_count, 0);

    // Periodic with 1: tc every enabled cycle
    drive(1, 1, 1, 1, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 1, 1, 0);
      check("per1_tc", {o_count, o_tc}, {8'd1, 1'b1});
    end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counter and countdown timer with a one-shot or periodic (auto-reload) mode. It counts down from a programmed value and flags terminal count.
It is the decrementing counterpart to the team's enable-gated up counter. It serves as a delay, timeout and tick generator for control logic in the same clock domain.

Parameters:
WIDTH, 8, bit width of the count, reload register and load value.

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  reset, synchronous, active-low; sampled on rising edge of clk
i_load  input  1  load strobe: capture i_load_value into reload register
i_load_value  input  WIDTH  reload / start value
i_start  input  1  start countdown (honoured in IDLE or DONE only)
i_enable  input  1  count enable (clock-enable style tick qualifier)
i_periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot
i_abort  input  1  stop countdown, return to IDLE
o_count  output  WIDTH  current count value
o_busy  output  1  high while in RUN
o_tc  output  1  one-cycle terminal-count pulse
o_done  output  1  high in DONE (one-shot expired), held until left

Behaviour:
- Reset: resetn low at a clk rising edge sets the following.
  - state=IDLE; o_count=0; reload_reg=0.
  - o_busy=0; o_tc=0; o_done=0.
  - Reset overrides every other input, including mid-RUN.
- States:
  - IDLE: waiting.
  - RUN: counting.
  - DONE: one-shot expired.
- Priority each cycle: resetn > i_abort > i_start > i_load.
- All outputs are registered. o_busy=(state==RUN). o_done=(state==DONE).
- o_tc defaults to 0 every cycle unless set by a rule below.
- i_abort, any state:
  - Next state is IDLE.
  - o_count holds its value; reload_reg is unchanged.
  - o_tc=0 and any pending load is ignored that cycle.
- i_load in IDLE or DONE: reload_reg<=i_load_value and o_count<=i_load_value; next state is IDLE (clears o_done).
- i_load in RUN: reload_reg<=i_load_value only. o_count is unaffected; the new value takes effect at the next reload or start.
- i_start in IDLE or DONE:
  - Start value is S = (i_load ? i_load_value : reload_reg). The same-cycle load bypass applies; reload_reg also updates if i_load.
  - S != 0: o_count<=S, next state is RUN.
  - S == 0: o_tc<=1 for one cycle, o_count<=0. Next state is DONE if i_periodic=0, else IDLE. Never enter RUN with zero.
- i_start in RUN is ignored (no restart).
- RUN, i_enable=0: o_count holds; no pulse.
- RUN, i_enable=1 and o_count>1: o_count<=o_count-1.
- RUN, i_enable=1 and o_count==1 (terminal): o_tc<=1, then by mode:
  - i_periodic=1: o_count<=R, where R = (i_load ? i_load_value : reload_reg); stay in RUN. If R==0, o_count<=0 and go to DONE.
  - i_periodic=0: o_count<=0, next state is DONE.
- Periodic period is exactly N enabled cycles for reload value N. N=1 gives o_tc on every enabled cycle.
- i_periodic is sampled only at terminal count. Changing it mid-run is legal.
- Arithmetic: unsigned; o_count never wraps below 0 and never exceeds 2^WIDTH-1. The 0x00→0xFF wrap is illegal and must be unreachable.
- DONE: o_count=0, o_done=1. Leave via i_start (restart with reload_reg), i_load (to IDLE) or i_abort.

Test Plan:
- Reset: drive resetn=0 for 2 clk mid-RUN with o_count=0x05 -> next edge o_count=0, o_busy=0, o_tc=0, o_done=0. Async glitch of resetn between edges has no effect.
- One-shot: load 3, i_periodic=0, start, i_enable=1 -> o_count 3,2,1,0. o_tc high exactly on the cycle o_count becomes 0. o_done=1 from then on; o_busy 1→0.
- Periodic with gaps: load 4, i_periodic=1, start, i_enable toggling 1,0,1,1,1 -> count 4,3,3,2,1,4. o_tc pulses once at the 1→4 reload; o_busy stays 1.
- Load during RUN: periodic, reload 5, at o_count=2 load 0x10 -> count continues 2,1, then reloads 0x10. Same-cycle load at terminal reloads i_load_value directly.
- Zero and boundary: start with reload_reg=0 -> single o_tc, state DONE, o_busy never 1. Load 0xFF, run 255 enabled cycles -> reaches 0 with no wrap; periodic with value 1 -> o_tc every enabled cycle.
- Priority: i_abort+i_start same cycle in DONE -> IDLE, o_count holds 0. i_start in RUN ignored (count unaffected). i_abort at o_count=0x07 -> IDLE, o_count=0x07, no o_tc.
